// File: rtl/fifo_wr_ingress.sv
// fifo_wr_ingress: write-domain ingress of the async FIFO.
//   - 2-entry skid buffer (output reg ov/od + skid reg sv/sd) between the
//     client valid/ready stream and the FIFO write port (winc/wdata).
//   - 2-flop synchronizer bringing the Gray read pointer into wclk.
//   - Registered fill level and almost-full flag from wptr and r_sync.
// Ports:
//   wclk, wrst        clock, synchronous active-low reset
//   s_valid/s_data    upstream word, s_ready back-pressure (registered)
//   rptr, wptr, wfull read ptr (async, Gray), write ptr (Gray), FIFO full
//   winc, wdata       write strobe / data to full logic and RAM
//   r_sync            rptr synchronized to wclk
//   wlevel            occupancy 0..2^addr_size, walmost_full threshold flag
module fifo_wr_ingress #(
  parameter int addr_size    = 4,
  parameter int data_size    = 8,
  parameter int afull_margin = 2
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 s_valid,
  input  logic [data_size-1:0] s_data,
  output logic                 s_ready,
  input  logic [addr_size:0]   rptr,
  input  logic [addr_size:0]   wptr,
  input  logic                 wfull,
  output logic                 winc,
  output logic [data_size-1:0] wdata,
  output logic [addr_size:0]   r_sync,
  output logic [addr_size:0]   wlevel,
  output logic                 walmost_full
);
  localparam int PW = addr_size + 1;
  localparam logic [PW-1:0] AFULL_TH = PW'((2 ** addr_size) - afull_margin);

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    for (int i = 0; i < PW; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  logic [PW-1:0]        rq1_q, rq1_d, r_sync_q, r_sync_d;
  logic [PW-1:0]        wlevel_q, wlevel_d;
  logic                 wafull_q, wafull_d;
  logic                 ov_q, ov_d, sv_q, sv_d, s_ready_q, s_ready_d;
  logic [data_size-1:0] od_q, od_d, sd_q, sd_d;
  logic                 drain, accept;

  assign drain  = ov_q & ~wfull;
  assign accept = s_valid & s_ready_q;

  always_comb begin
    rq1_d    = rptr;
    r_sync_d = rq1_q;
    // Modulo-2^PW subtraction handles wraparound of either pointer.
    wlevel_d = g2b(wptr) - g2b(r_sync_q);
    wafull_d = (wlevel_d >= AFULL_TH);

    ov_d = ov_q;
    od_d = od_q;
    sv_d = sv_q;
    sd_d = sd_q;
    if (sv_q) begin
      // s_ready is low while the skid is occupied, so no accept here.
      if (drain) begin
        ov_d = 1'b1;
        od_d = sd_q;
        sv_d = 1'b0;
      end
    end else if (drain || !ov_q) begin
      ov_d = accept;
      if (accept) od_d = s_data;
    end else if (accept) begin
      // Output held by wfull: park the word in the skid.
      sv_d = 1'b1;
      sd_d = s_data;
    end
    s_ready_d = ~sv_d;
  end

  always_ff @(posedge wclk) begin
    if (!wrst) begin
      rq1_q     <= '0;
      r_sync_q  <= '0;
      wlevel_q  <= '0;
      wafull_q  <= 1'b0;
      ov_q      <= 1'b0;
      od_q      <= '0;
      sv_q      <= 1'b0;
      sd_q      <= '0;
      s_ready_q <= 1'b0;
    end else begin
      rq1_q     <= rq1_d;
      r_sync_q  <= r_sync_d;
      wlevel_q  <= wlevel_d;
      wafull_q  <= wafull_d;
      ov_q      <= ov_d;
      od_q      <= od_d;
      sv_q      <= sv_d;
      sd_q      <= sd_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign winc         = ov_q & ~wfull;
  assign wdata        = od_q;
  assign r_sync       = r_sync_q;
  assign wlevel       = wlevel_q;
  assign walmost_full = wafull_q;
endmodule

// File: tb/tb_fifo_wr_ingress.sv
// Directed bench for fifo_wr_ingress (addr_size=4, data_size=8, margin=2).
module tb_fifo_wr_ingress;
  logic       wclk = 1'b0;
  logic       wrst, s_valid, s_ready, wfull, winc, walmost_full;
  logic [7:0] s_data, wdata;
  logic [4:0] rptr, wptr, r_sync, wlevel;
  int         n_chk = 0, n_pass = 0;

  always #5 wclk = ~wclk;

  fifo_wr_ingress #(.addr_size(4), .data_size(8), .afull_margin(2)) dut (
    .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .rptr(rptr), .wptr(wptr), .wfull(wfull),
    .winc(winc), .wdata(wdata), .r_sync(r_sync), .wlevel(wlevel),
    .walmost_full(walmost_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step(input int n = 1);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  initial begin
    wrst = 1'b0; s_valid = 1'b0; s_data = '0; wfull = 1'b0;
    rptr = '0; wptr = '0;
    step(2);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_winc", 32'(winc), 0);
    chk("rst_r_sync", 32'(r_sync), 0);
    chk("rst_wlevel", 32'(wlevel), 0);
    chk("rst_afull", 32'(walmost_full), 0);

    wrst = 1'b1;
    step();
    chk("rdy_after_rst", 32'(s_ready), 1);

    // 16 back-to-back words
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      step();
      chk("stream_winc", 32'(winc), 1);
      chk("stream_wdata", 32'(wdata), 32'(i));
      chk("stream_rdy", 32'(s_ready), 1);
    end
    s_valid = 1'b0;
    step();
    chk("stream_end_winc", 32'(winc), 0);

    // Back-pressure: output + skid absorb two words
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'h20;
    step();
    chk("bp_out_held", 32'(winc), 0);
    chk("bp_rdy1", 32'(s_ready), 1);
    s_data = 8'h21;
    step();
    chk("bp_rdy0", 32'(s_ready), 0);
    chk("bp_wdata", 32'(wdata), 32'h20);
    s_data = 8'h22;
    step(3);
    chk("bp_hold_rdy", 32'(s_ready), 0);
    chk("bp_hold_wdata", 32'(wdata), 32'h20);
    chk("bp_hold_winc", 32'(winc), 0);
    wfull = 1'b0;
    #1;
    chk("rel_winc_comb", 32'(winc), 1);
    chk("rel_wdata0", 32'(wdata), 32'h20);
    step();
    chk("rel_wdata1", 32'(wdata), 32'h21);
    chk("rel_winc1", 32'(winc), 1);
    chk("rel_rdy", 32'(s_ready), 1);
    step();
    chk("rel_wdata2", 32'(wdata), 32'h22);
    chk("rel_winc2", 32'(winc), 1);
    s_valid = 1'b0;
    step();
    chk("rel_empty", 32'(winc), 0);

    // Synchronizer: rptr 0 -> gray(1)
    rptr = 5'h01;
    step();
    chk("sync_rq1", 32'(dut.rq1_q), 1);
    chk("sync_1edge", 32'(r_sync), 0);
    step();
    chk("sync_2edge", 32'(r_sync), 1);

    // Level / almost-full threshold
    rptr = 5'h00; wptr = 5'h09;           // gray(14)
    step(3);
    chk("lvl14", 32'(wlevel), 14);
    chk("afull14", 32'(walmost_full), 1);
    wptr = 5'h0B;                          // gray(13)
    step();
    chk("lvl13", 32'(wlevel), 13);
    chk("afull13", 32'(walmost_full), 0);

    // Wrap: wbin=3, rbin=19 -> 16; then equal -> 0
    wptr = 5'h02; rptr = 5'h1A;
    step(3);
    chk("wrap_full", 32'(wlevel), 16);
    chk("wrap_afull", 32'(walmost_full), 1);
    wptr = 5'h1E; rptr = 5'h1E;
    step(3);
    chk("wrap_zero", 32'(wlevel), 0);
    chk("wrap_zero_af", 32'(walmost_full), 0);

    // Reset mid-stream with ov = sv = 1
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'h30;
    step();
    s_data = 8'h31;
    step();
    chk("mid_rdy0", 32'(s_ready), 0);
    wrst = 1'b0; wfull = 1'b0; s_valid = 1'b0;
    step();
    chk("mid_rst_winc", 32'(winc), 0);
    chk("mid_rst_rdy", 32'(s_ready), 0);
    wrst = 1'b1;
    step();
    chk("mid_rel_rdy", 32'(s_ready), 1);
    chk("mid_rel_winc", 32'(winc), 0);
    s_valid = 1'b1; s_data = 8'h40;
    step();
    chk("mid_new_winc", 32'(winc), 1);
    chk("mid_new_wdata", 32'(wdata), 32'h40);
    s_valid = 1'b0;
    step();
    chk("mid_new_empty", 32'(winc), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
